sram_arbiter: RTL



---
 rtl/sram_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Shares one 16-bit SRAM between port A (MEM stage) and port B; each 32-bit access runs as a LO then HI half-word phase.
// Build option SRAM_ARB_FAIR_EN: round-robin on simultaneous requests; without it port A has fixed priority.
module sram_arbiter #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_rd_en,
    input  logic        a_wr_en,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        pause_a,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] rdata,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int               CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              grant_b_r, grant_b_s;
    logic              we_r, we_s;
    logic [16:0]       word_r, word_s;
    logic [31:0]       wdata_r, wdata_s;
    logic [31:0]       rdata_r;
    logic              b_ack_r;
    logic [17:0]       addr_r, addr_s;
    logic              ce_n_r, ce_n_s;
    logic              oe_n_r, oe_n_s;
    logic              we_n_r, we_n_s;
    logic              dq_oe_r, dq_oe_s;
    logic [15:0]       dq_out_r, dq_out_s;
    logic              a_req_s;
    logic              phase_end_s;
    logic              active_s;
    logic              hi_s;
    logic [31:0]       req_addr_s;
    logic [31:0]       offset_s;
    logic              unused_s;

    assign a_req_s = a_rd_en | a_wr_en;

`ifdef SRAM_ARB_FAIR_EN
    logic last_b_r;

    // Round-robin grant: on a tie the port not served last wins
    always_comb begin
        if (a_req_s && b_req) begin
            grant_b_s = ~last_b_r;
        end else begin
            grant_b_s = ~a_req_s & b_req;
        end
    end

    // Remember which port received the most recent grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && (a_req_s || b_req)) begin
            last_b_r <= grant_b_s;
        end else begin
            last_b_r <= last_b_r;
        end
    end
`else
    // Fixed priority: B only wins when A is silent
    always_comb begin
        grant_b_s = ~a_req_s & b_req;
    end
`endif

    // Select the winning request; it is latched only when leaving IDLE
    always_comb begin
        req_addr_s = grant_b_s ? b_addr : a_addr;
        offset_s   = req_addr_s - ADDR_BASE;
        if (state_r == ST_IDLE) begin
            we_s    = grant_b_s ? b_we : a_wr_en;
            word_s  = offset_s[18:2];
            wdata_s = grant_b_s ? b_wdata : a_wdata;
        end else begin
            we_s    = we_r;
            word_s  = word_r;
            wdata_s = wdata_r;
        end
    end

    // Byte-offset and high address bits fall outside the 18-bit half-word space
    assign unused_s = ^{offset_s[31:19], offset_s[1:0]};

    // Sequencer next state and phase counter
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        phase_end_s = (cnt_r == CNT_LAST);
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (a_req_s || b_req) begin
                    state_s = ST_LO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (phase_end_s) begin
                    state_s = ST_HI;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_LO;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (phase_end_s) begin
                    state_s = ST_DONE;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_HI;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Pin values for the coming cycle; WE_N rises on the last phase cycle for hold time
    always_comb begin
        active_s = (state_s == ST_LO) || (state_s == ST_HI);
        hi_s     = (state_s == ST_HI);
        ce_n_s   = ~active_s;
        oe_n_s   = ~(active_s & ~we_s);
        we_n_s   = ~(active_s & we_s & (cnt_s != CNT_LAST));
        dq_oe_s  = active_s & we_s;
        addr_s   = active_s ? {word_s, hi_s} : 18'd0;
        dq_out_s = hi_s ? wdata_s[31:16] : wdata_s[15:0];
    end

    // Sequencer state and latched request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            grant_b_r <= 1'b0;
            we_r      <= 1'b0;
            word_r    <= 17'd0;
            wdata_r   <= 32'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            we_r      <= we_s;
            word_r    <= word_s;
            wdata_r   <= wdata_s;
            if (state_r == ST_IDLE) begin
                grant_b_r <= grant_b_s;
            end else begin
                grant_b_r <= grant_b_r;
            end
        end
    end

    // Registered SRAM pins and B completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r   <= 18'd0;
            ce_n_r   <= 1'b1;
            oe_n_r   <= 1'b1;
            we_n_r   <= 1'b1;
            dq_oe_r  <= 1'b0;
            dq_out_r <= 16'd0;
            b_ack_r  <= 1'b0;
        end else begin
            addr_r   <= addr_s;
            ce_n_r   <= ce_n_s;
            oe_n_r   <= oe_n_s;
            we_n_r   <= we_n_s;
            dq_oe_r  <= dq_oe_s;
            dq_out_r <= dq_out_s;
            b_ack_r  <= (state_s == ST_DONE) & grant_b_r;
        end
    end

    // Read data capture on the last cycle of each read phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 32'd0;
        end else if ((state_r == ST_LO) && phase_end_s && !we_r) begin
            rdata_r[15:0] <= SRAM_DQ;
        end else if ((state_r == ST_HI) && phase_end_s && !we_r) begin
            rdata_r[31:16] <= SRAM_DQ;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign pause_a   = a_req_s & ~((state_r == ST_DONE) & ~grant_b_r);
    assign b_ack     = b_ack_r;
    assign rdata     = rdata_r;
    assign SRAM_ADDR = addr_r;
    assign SRAM_CE_N = ce_n_r;
    assign SRAM_UB_N = ce_n_r;
    assign SRAM_LB_N = ce_n_r;
    assign SRAM_OE_N = oe_n_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;

endmodule
